// File: rtl/vec_mag_pkg.sv
// Shared definitions for the vector-magnitude statistics block: width defaults,
// the result record layout and its packing onto the output stream.
package vec_mag_pkg;

  localparam int COORD_WIDTH_DEF = 8;
  localparam int IN_WIDTH_DEF    = 4 * COORD_WIDTH_DEF;
  localparam int MAG_WIDTH_DEF   = 8;
  localparam int CNT_WIDTH_DEF   = 16;
  localparam int SUM_WIDTH_DEF   = MAG_WIDTH_DEF + CNT_WIDTH_DEF;
  localparam int OUT_WIDTH_DEF   = 1 + SUM_WIDTH_DEF + MAG_WIDTH_DEF + CNT_WIDTH_DEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vec_mag_state_t;

  // Field order matches the output beat: count sits in the LSBs
  typedef struct packed {
    logic                     ovf;
    logic [SUM_WIDTH_DEF-1:0] sum;
    logic [MAG_WIDTH_DEF-1:0] max;
    logic [CNT_WIDTH_DEF-1:0] count;
  } vec_mag_stats_t;

  function automatic logic [OUT_WIDTH_DEF-1:0] vec_mag_pack(input vec_mag_stats_t stats);
    return stats;
  endfunction

endpackage

// File: rtl/vec_mag_axis_reg.sv
// Single-entry AXI-Stream holding register: loads a word, holds it until the
// downstream accepts it, and tells the producer when a new load is allowed.
module vec_mag_axis_reg #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  assign s_ready  = !valid_reg || m_tready;
  assign m_tdata  = data_reg;
  assign m_tvalid = valid_reg;

  // A load is only issued while s_ready is high, so it never overwrites an undrained word
  always_ff @(posedge aclk) begin
    if (areset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (m_tready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_mag_pkt_stats.sv
// Per-packet beat count / sum / max over a magnitude stream, one result beat per packet.
// Define VEC_MAG_STATS_SAT_EN to saturate count/sum and report a sticky ovf bit.
module vec_mag_pkt_stats
  import vec_mag_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int MAG_WIDTH = MAG_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [CNT_WIDTH-1:0]               cfg_pkt_len,
  input  logic [IN_WIDTH-1:0]                s_axis_tdata,
  input  logic                               s_axis_tvalid,
  input  logic                               s_axis_tlast,
  output logic                               s_axis_tready,
  output logic [2*MAG_WIDTH+2*CNT_WIDTH:0]   m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready
);

  localparam int SUM_WIDTH = MAG_WIDTH + CNT_WIDTH;
  localparam int OUT_WIDTH = 1 + SUM_WIDTH + MAG_WIDTH + CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  vec_mag_state_t       state_reg, state_next;
  logic [CNT_WIDTH-1:0] len_reg, len_next, cnt_reg, cnt_next;
  logic [SUM_WIDTH-1:0] sum_reg, sum_next;
  logic [MAG_WIDTH-1:0] max_reg, max_next;
  logic                 ovf_reg, ovf_next;

  logic [MAG_WIDTH-1:0] mag;
  logic [SUM_WIDTH-1:0] mag_ext;
  logic [CNT_WIDTH-1:0] len_eff, cur_cnt, upd_cnt;
  logic [SUM_WIDTH-1:0] cur_sum, upd_sum;
  logic [MAG_WIDTH-1:0] cur_max, upd_max;
  logic                 cur_ovf, upd_ovf;
  logic                 accept, close, load;
  logic [OUT_WIDTH-1:0] result;

  assign mag          = s_axis_tdata[MAG_WIDTH-1:0];
  assign mag_ext      = {{CNT_WIDTH{1'b0}}, mag};
  assign accept       = s_axis_tvalid && s_axis_tready;
  assign m_axis_tlast = 1'b1;

  generate
    if (IN_WIDTH > MAG_WIDTH) begin : g_upper
      logic unused_upper_tdata;
      assign unused_upper_tdata = ^s_axis_tdata[IN_WIDTH-1:MAG_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_reg;
    max_next   = max_reg;
    ovf_next   = ovf_reg;
    load       = 1'b0;

    // In IDLE the first beat starts from empty accumulators and a freshly sampled length
    if (state_reg == ST_IDLE) begin
      len_eff = cfg_pkt_len;
      cur_cnt = '0;
      cur_sum = '0;
      cur_max = '0;
      cur_ovf = 1'b0;
    end else begin
      len_eff = len_reg;
      cur_cnt = cnt_reg;
      cur_sum = sum_reg;
      cur_max = max_reg;
      cur_ovf = ovf_reg;
    end

    upd_max = (mag > cur_max) ? mag : cur_max;
`ifdef VEC_MAG_STATS_SAT_EN
    if (&cur_cnt) begin
      upd_cnt = cur_cnt;
      upd_sum = cur_sum;
      upd_ovf = 1'b1;
    end else begin
      upd_cnt = cur_cnt + CNT_ONE;
      upd_sum = cur_sum + mag_ext;
      upd_ovf = cur_ovf;
    end
`else
    // Nothing ever sets ovf here, so it remains 0
    upd_cnt = cur_cnt + CNT_ONE;
    upd_sum = cur_sum + mag_ext;
    upd_ovf = cur_ovf;
`endif

    close  = (len_eff == '0) ? s_axis_tlast : (upd_cnt == len_eff);
    result = {upd_ovf, upd_sum, upd_max, upd_cnt};

    if (accept) begin
      len_next = len_eff;
      cnt_next = upd_cnt;
      sum_next = upd_sum;
      max_next = upd_max;
      ovf_next = upd_ovf;
      if (close) begin
        load       = 1'b1;
        state_next = ST_IDLE;
      end else begin
        state_next = ST_RUN;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      max_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      sum_reg   <= sum_next;
      max_reg   <= max_next;
      ovf_reg   <= ovf_next;
    end
  end

  vec_mag_axis_reg #(
    .WIDTH(OUT_WIDTH)
  ) u_out_reg (
    .aclk      (aclk),
    .areset    (areset),
    .load      (load),
    .load_data (result),
    .s_ready   (s_axis_tready),
    .m_tdata   (m_axis_tdata),
    .m_tvalid  (m_axis_tvalid),
    .m_tready  (m_axis_tready)
  );

endmodule

// File: doc/vec_mag_pkt_stats.md
Name: vec_mag_pkt_stats

Overview:
- Downstream consumer of the vector-magnitude pipeline's AXI-Stream output.
- Accumulates per-packet statistics over incoming magnitude beats: beat count, running sum and maximum.
- Emits one result beat per closed packet on an AXI-Stream master.
- A packet closes on s_axis_tlast, or after a programmable beat count. The programmable count is needed because the upstream core drives tlast=1 on every beat.

Parameters:
- IN_WIDTH, 32, width of s_axis_tdata; matches upstream tdata width (4*COORD_WIDTH at COORD_WIDTH=8).
- MAG_WIDTH, 8, magnitude bits taken from s_axis_tdata[MAG_WIDTH-1:0]; upper bits ignored.
- CNT_WIDTH, 16, width of the beat counter and of cfg_pkt_len.
- Derived: SUM_WIDTH = MAG_WIDTH+CNT_WIDTH; OUT_WIDTH = 1+SUM_WIDTH+MAG_WIDTH+CNT_WIDTH (49 at defaults).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- cfg_pkt_len  in  CNT_WIDTH  0 = tlast-delimited packets; N>0 = packet closes after N beats.
- s_axis_tdata  in  IN_WIDTH  magnitude in low MAG_WIDTH bits, unsigned.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  end of packet (used only when the latched length is 0).
- s_axis_tready  out  1  input accept.
- m_axis_tdata  out  OUT_WIDTH  {ovf, sum, max, count}; count at LSBs.
- m_axis_tvalid  out  1  result valid.
- m_axis_tlast  out  1  constant 1; every result is a single-beat packet.
- m_axis_tready  in  1  downstream accept.

Behaviour:
- Beat accepted when s_axis_tvalid && s_axis_tready. Result transferred when m_axis_tvalid && m_axis_tready.
- s_axis_tready = !m_axis_tvalid || m_axis_tready, combinational.
  - Stalls all input while an undrained result is held.
- FSM, 2 states:
  - IDLE (no beats in the current packet). First accepted beat latches cfg_pkt_len into len_q and initialises count=1, sum=mag, max=mag. Goes to RUN unless that beat closes the packet.
  - RUN: each accepted beat does count+1, sum+mag, max=max(max,mag).
- Close condition on an accepted beat:
  - len_q==0: close on tlast.
  - len_q!=0: close when the post-increment count == len_q; tlast is ignored.
  - On close: the output register loads the final stats including the closing beat; m_axis_tvalid=1 on the next cycle; FSM returns to IDLE.
- Latency: result visible 1 cycle after the closing beat is accepted.
- Single-beat packet: closes from IDLE directly; count=1, sum=max=mag.
- Back-to-back closes:
  - A held result draining in the same cycle as a new close: the new result loads and m_axis_tvalid stays 1.
  - No bubble is required, and no result is lost.
- Output register holds its value while m_axis_tvalid && !m_axis_tready.
- A cfg_pkt_len change mid-packet has no effect until the next packet's first beat.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, FSM=IDLE, all accumulators 0.
  - s_axis_tready is 1 in the cycle after reset.
- Reset mid-packet: partial accumulation and any held result are discarded.
- Sum cannot overflow unless count wraps, since SUM_WIDTH covers (2^CNT-1)*(2^MAG-1).

Optional Feature:
- Macro VEC_MAG_STATS_SAT_EN.
- Defined:
  - count saturates at all-ones; further beats leave count and sum unchanged.
  - max continues to update.
  - Sticky ovf bit set for that packet.
  - A length-terminated packet still closes at len_q.
- Undefined:
  - count and sum wrap modulo 2^width.
  - ovf bit tied 0.

Decomposition:
- Shared package vec_mag_pkg holds:
  - COORD_WIDTH/IN_WIDTH defaults and the MAG_WIDTH/CNT_WIDTH defaults.
  - A packed struct typedef vec_mag_stats_t {ovf, sum, max, count}.
  - A pack function that returns the struct laid out as the m_axis_tdata bit vector.
- One natural sub-module: vec_mag_axis_reg, a single-entry AXI-Stream output holding register with valid/ready (load/hold/drain). The core module keeps the FSM and accumulators.

Test Plan:
- cfg=0; beats 3,7,5 with tlast on 5, m_tready=1 -> one result count=3 sum=15 max=7 ovf=0, 1 cycle after the third beat.
- cfg=4; continuous beats 10,20,30,40,1,2,3,4 with tlast=1 every beat -> results (4,100,40) then (4,10,4); tlast ignored.
- cfg=0; tlast every beat (mags 9,2), m_tready held 0 for 5 cycles -> first result (1,9,9) held stable; s_tready=0; no beat lost. Release -> second result (1,2,2) follows with no bubble.
- cfg=0; upper tdata bits 0xFFFFFF, low byte 0x11, tlast -> max=0x11, sum=0x11.
- areset pulse after 2 of 4 beats (cfg=4) -> no output; the next 4 beats of 1 -> (4,4,1).
- With SAT_EN, CNT_WIDTH=2, cfg=0: 5 beats of 3, last with tlast -> count=3 sum=9 max=3 ovf=1. Without SAT_EN -> count=1 sum=15 ovf=0.
